// File: rtl/mem_address_scanner.sv
// BRAM port-B inspection address generator: debounced inc/dec buttons, periodic auto-scan
// and direct load, producing a registered, range-limited, wrapping address.
module mem_address_scanner #(
    parameter int P_ADDRESS_WIDTH   = 10,
    parameter int P_DEBOUNCE_CYCLES = 500000,
    parameter int P_SCAN_PERIOD     = 50000000,
    parameter int P_MIN_ADDRESS     = 0,
    parameter int P_MAX_ADDRESS     = 1023
) (
    input  logic                       I_CLK,
    input  logic                       I_RESET,
    input  logic                       I_BTN_INC,
    input  logic                       I_BTN_DEC,
    input  logic                       I_SCAN_ENABLE,
    input  logic                       I_LOAD,
    input  logic [P_ADDRESS_WIDTH-1:0] I_LOAD_ADDRESS,
    output logic [P_ADDRESS_WIDTH-1:0] O_MEM_ADDRESS_B,
    output logic                       O_STEP_PULSE,
    output logic                       O_SCAN_ACTIVE
);

    localparam int AW = P_ADDRESS_WIDTH;
    localparam int DW = (P_DEBOUNCE_CYCLES > 2) ? $clog2(P_DEBOUNCE_CYCLES) : 1;
    localparam int SW = (P_SCAN_PERIOD > 2) ? $clog2(P_SCAN_PERIOD) : 1;

    localparam logic [DW-1:0] DEB_LAST  = DW'(P_DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(P_SCAN_PERIOD - 1);
    localparam logic [AW-1:0] ADDR_MIN  = AW'(P_MIN_ADDRESS);
    localparam logic [AW-1:0] ADDR_MAX  = AW'(P_MAX_ADDRESS);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SCAN = 1'b1;

    function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
        if (a >= ADDR_MAX) begin
            addr_inc = ADDR_MIN;
        end else begin
            addr_inc = a + AW'(1);
        end
    endfunction

    function automatic logic [AW-1:0] addr_dec(input logic [AW-1:0] a);
        if (a <= ADDR_MIN) begin
            addr_dec = ADDR_MAX;
        end else begin
            addr_dec = a - AW'(1);
        end
    endfunction

    function automatic logic [AW-1:0] addr_clamp(input logic [AW-1:0] a);
        if (a < ADDR_MIN) begin
            addr_clamp = ADDR_MIN;
        end else if (a > ADDR_MAX) begin
            addr_clamp = ADDR_MAX;
        end else begin
            addr_clamp = a;
        end
    endfunction

    // bit 0 = inc button, bit 1 = dec button, bit 2 = scan switch
    logic [2:0]         sync1_q, sync2_q;
    logic [1:0][DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [1:0]         deb_q, deb_d, deb_dly_q;
    logic [1:0]         step_s;
    logic [0:0]         state_q, state_d;
    logic [SW-1:0]      presc_q, presc_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic               pulse_q, pulse_d;
    logic               scan_active_q;
    logic               tick_s;

    // Debounce: level flips only after DEB cycles of uninterrupted disagreement
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        deb_d     = deb_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    deb_d[i]     = sync2_q[i];
                    deb_cnt_d[i] = {DW{1'b0}};
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
                end
            end else begin
                deb_cnt_d[i] = {DW{1'b0}};
            end
        end
    end

    assign step_s = deb_q & ~deb_dly_q;
    assign tick_s = (state_q == S_SCAN) && (presc_q == SCAN_LAST);

    // Scan FSM, prescaler and prioritised address update (load > step > tick)
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        addr_d  = addr_q;
        pulse_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                presc_d = {SW{1'b0}};
                if (sync2_q[2]) begin
                    state_d = S_SCAN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SCAN: begin
                if (!sync2_q[2]) begin
                    state_d = S_IDLE;
                    presc_d = {SW{1'b0}};
                end else if (presc_q == SCAN_LAST) begin
                    presc_d = {SW{1'b0}};
                end else begin
                    presc_d = presc_q + SW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                presc_d = {SW{1'b0}};
            end
        endcase

        if (I_LOAD) begin
            addr_d  = addr_clamp(I_LOAD_ADDRESS);
            pulse_d = 1'b1;
            presc_d = {SW{1'b0}};
        end else if (step_s == 2'b01) begin
            addr_d  = addr_inc(addr_q);
            pulse_d = 1'b1;
            presc_d = {SW{1'b0}};
        end else if (step_s == 2'b10) begin
            addr_d  = addr_dec(addr_q);
            pulse_d = 1'b1;
            presc_d = {SW{1'b0}};
        end else if (step_s == 2'b11) begin
            // simultaneous inc and dec cancel and also swallow any tick this cycle
            addr_d  = addr_q;
        end else if (tick_s) begin
            addr_d  = addr_inc(addr_q);
            pulse_d = 1'b1;
        end else begin
            addr_d  = addr_q;
        end
    end

    // State registers with asynchronous active-high reset
    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            sync1_q       <= 3'b000;
            sync2_q       <= 3'b000;
            deb_cnt_q     <= {2*DW{1'b0}};
            deb_q         <= 2'b00;
            deb_dly_q     <= 2'b00;
            state_q       <= S_IDLE;
            presc_q       <= {SW{1'b0}};
            addr_q        <= ADDR_MIN;
            pulse_q       <= 1'b0;
            scan_active_q <= 1'b0;
        end else begin
            sync1_q       <= {I_SCAN_ENABLE, I_BTN_DEC, I_BTN_INC};
            sync2_q       <= sync1_q;
            deb_cnt_q     <= deb_cnt_d;
            deb_q         <= deb_d;
            deb_dly_q     <= deb_q;
            state_q       <= state_d;
            presc_q       <= presc_d;
            addr_q        <= addr_d;
            pulse_q       <= pulse_d;
            scan_active_q <= (state_d == S_SCAN);
        end
    end

    assign O_MEM_ADDRESS_B = addr_q;
    assign O_STEP_PULSE    = pulse_q;
    assign O_SCAN_ACTIVE   = scan_active_q;

endmodule

// File: doc/mem_address_scanner.md
Name: mem_address_scanner

Overview:
Upstream driver for the CR16 top-level's BRAM port-B inspection address (the value shown on the 7-segment display). Converts raw push-buttons and a scan switch into a registered, range-limited, wrapping address. Modes: manual step (debounced inc/dec buttons), auto-scan (periodic increment), direct load. Output feeds the BRAM port-B address input directly.

Parameters:
P_ADDRESS_WIDTH, 10, width of generated address
P_DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a button level change (min 2)
P_SCAN_PERIOD, 50000000, clock cycles between auto-scan increments (min 2)
P_MIN_ADDRESS, 0, lowest address produced
P_MAX_ADDRESS, 1023, highest address produced (P_MIN_ADDRESS < P_MAX_ADDRESS < 2^P_ADDRESS_WIDTH)

Ports:
I_CLK  input  1  system clock, all logic on rising edge
I_RESET  input  1  asynchronous, active-high reset
I_BTN_INC  input  1  raw increment button, asynchronous, active-high
I_BTN_DEC  input  1  raw decrement button, asynchronous, active-high
I_SCAN_ENABLE  input  1  raw auto-scan switch, asynchronous level
I_LOAD  input  1  synchronous single-cycle load strobe
I_LOAD_ADDRESS  input  P_ADDRESS_WIDTH  address captured on I_LOAD
O_MEM_ADDRESS_B  output  P_ADDRESS_WIDTH  registered inspection address
O_STEP_PULSE  output  1  high for exactly one cycle, coincident with each accepted address update
O_SCAN_ACTIVE  output  1  high while FSM in SCAN

Behaviour:
- Clock I_CLK only; reset is asynchronous and active-high (I_RESET). Reset: O_MEM_ADDRESS_B=P_MIN_ADDRESS, O_STEP_PULSE=0, O_SCAN_ACTIVE=0, FSM=IDLE, all sync flops/debounced levels/counters=0. Reset mid-operation aborts any debounce or scan count immediately.
- Synchronisation: I_BTN_INC, I_BTN_DEC, I_SCAN_ENABLE each pass through 2 flops. I_LOAD/I_LOAD_ADDRESS are already synchronous.
- Debounce (per button): counter advances each cycle synced level != debounced level; reset to 0 whenever they match (glitch shorter than P_DEBOUNCE_CYCLES is discarded). Debounced level flips on the edge where counter would reach P_DEBOUNCE_CYCLES. Step request = debounced rising edge only (holding produces one step; release produces none).
- Latency: constant raw button high -> address update 3+P_DEBOUNCE_CYCLES rising edges after first edge sampling it high.
- FSM: IDLE -> SCAN when synced scan enable=1; SCAN -> IDLE when 0. On every transition prescaler clears. In SCAN prescaler counts 0..P_SCAN_PERIOD-1; at terminal count generates scan tick and wraps to 0. First tick P_SCAN_PERIOD cycles after SCAN entry.
- Update priority per cycle: I_LOAD > button step > scan tick. Lower-priority event in same cycle is dropped (not deferred). Any load or button step in SCAN also clears prescaler.
- Inc and dec step requests in same cycle: cancel, no update, no pulse.
- Wrap: inc at P_MAX_ADDRESS -> P_MIN_ADDRESS; dec at P_MIN_ADDRESS -> P_MAX_ADDRESS. Scan tick follows inc wrap.
- Load: value < P_MIN_ADDRESS clamps to P_MIN_ADDRESS; > P_MAX_ADDRESS clamps to P_MAX_ADDRESS. Accepted loads always pulse O_STEP_PULSE, even if value unchanged.
- O_STEP_PULSE and O_MEM_ADDRESS_B registered together; never high two consecutive cycles from a single button press.

Test Plan:
(Bench params: P_DEBOUNCE_CYCLES=4, P_SCAN_PERIOD=8, P_MIN_ADDRESS=2, P_MAX_ADDRESS=5.)
- Reset, then hold I_BTN_INC high -> O_MEM_ADDRESS_B 2->3 exactly 7 edges after first high sample, one-cycle O_STEP_PULSE, no further change while held; 3-cycle glitch on I_BTN_DEC -> no change.
- Four debounced INC presses from 2 -> 3,4,5,2 (wrap); one DEC press at 2 -> 5.
- I_SCAN_ENABLE=1 -> O_SCAN_ACTIVE after 2 sync edges + 1; address increments every 8 cycles 2,3,4,5,2; deassert -> O_SCAN_ACTIVE=0, no further increments.
- I_LOAD with 9 -> address 5; with 0 -> 2; with 4 -> 4; pulse each time; load in same cycle as debounced INC step -> loaded value only, single pulse.
- INC and DEC debounced same cycle -> address unchanged, no pulse.
- Assert I_RESET asynchronously mid-scan and mid-debounce -> outputs return to 2/0/0 before next clock edge; after release, no spurious step.
